// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder slice: access-size
// encodings, responder FSM states and the byte-lane count of a data word.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int unsigned LANES = 4;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane decode for a data-memory store.
// Optional feature macro: DMEM_RSP_MISALIGN_ERR_EN (flags misaligned/reserved
// accesses instead of force-aligning them).
// Ports:
//   size      in  2   access size (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD)
//   addr      in  2   low byte-address bits
//   wdata     in  32  right-justified store data
//   be        out 4   byte enables of the lanes written
//   wdata_rep out 32  store data replicated across lanes
//   misalign  out 1   access is misaligned or reserved (0 when feature off)
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign
);

  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (size_e'(size))
      SZ_BYTE: begin
        be        = 4'b0001 << addr;
        wdata_rep = {LANES{wdata[7:0]}};
      end
      SZ_HALF: begin
        // Without the error feature addr[0] is ignored: half forced to
        // its naturally aligned pair of lanes.
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
`ifdef DMEM_RSP_MISALIGN_ERR_EN
        misalign  = addr[0];
`endif
      end
      SZ_WORD: begin
        be = '1;
`ifdef DMEM_RSP_MISALIGN_ERR_EN
        misalign = |addr;
`endif
      end
      default: begin
        // Reserved size behaves as a word access unless flagged.
        be = '1;
`ifdef DMEM_RSP_MISALIGN_ERR_EN
        misalign = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the core's load/store request path.
// Accepts one request at a time (valid/ready), holds it for LATENCY cycles,
// performs a byte-lane-masked access to an internal word array and returns
// the full addressed word on a valid/ready response channel.
// Optional feature macro: DMEM_RSP_MISALIGN_ERR_EN (misaligned/reserved
// accesses report rsp_err, suppress the store and return zero data).
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready, req_we, req_size[1:0], req_addr[31:0], req_wdata[31:0]
//   rsp_valid/rsp_ready, rsp_rdata[31:0], rsp_err
//   busy  high in WAIT or RESP
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    armed_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  logic                    accept, latch_en, commit;
  logic                    c_we;
  logic [1:0]              c_size;
  logic [31:0]             c_addr;
  logic [DATA_WIDTH-1:0]   c_wdata;
  logic [ADDR_WIDTH-1:0]   c_idx;
  logic [3:0]              be;
  logic [DATA_WIDTH-1:0]   wdata_rep, mask, old_word, new_word;
  logic                    misalign, err_now;
  logic                    unused_bits;

  // armed_q keeps req_ready low until the first edge after reset release.
  assign req_ready = (state_q == IDLE) && armed_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q == WAIT) || (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;

  // With LATENCY=1 the access commits on the accept edge itself, so the
  // commit operands come straight from the request port in IDLE.
  assign c_we    = (state_q == IDLE) ? req_we    : we_q;
  assign c_size  = (state_q == IDLE) ? req_size  : size_q;
  assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign c_idx   = c_addr[ADDR_WIDTH+1:2];

  dmem_lane_ctrl u_lane_ctrl (
    .size      (c_size),
    .addr      (c_addr[1:0]),
    .wdata     (c_wdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .misalign  (misalign)
  );

`ifdef DMEM_RSP_MISALIGN_ERR_EN
  assign err_now = misalign;
`else
  assign err_now = 1'b0;
`endif

  assign unused_bits = ^{c_addr[31:ADDR_WIDTH+2], misalign};

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      mask[i*8 +: 8] = {8{be[i]}};
    end
  end

  assign old_word = mem[c_idx];
  assign new_word = (old_word & ~mask) | (wdata_rep & mask);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          latch_en = 1'b1;
          if (LATENCY == 1) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < 2**ADDR_WIDTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
      if (latch_en) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        if (c_we && !err_now) mem[c_idx] <= new_word;
        rdata_q <= err_now ? '0 : (c_we ? new_word : old_word);
        err_q   <= err_now;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  // Extra instances for latency-1 and latency-15 spacing checks.
  logic        v1 = 1'b0, v15 = 1'b0;
  logic        rdy1, rv1, err1, busy1, rdy15, rv15, err15, busy15;
  logic [31:0] rd1, rd15;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1),
    .req_we(1'b0), .req_size(2'b10), .req_addr(32'h0), .req_wdata(32'h0),
    .rsp_valid(rv1), .rsp_ready(1'b1), .rsp_rdata(rd1), .rsp_err(err1),
    .busy(busy1)
  );

  dmem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst), .req_valid(v15), .req_ready(rdy15),
    .req_we(1'b0), .req_size(2'b10), .req_addr(32'h0), .req_wdata(32'h0),
    .rsp_valid(rv15), .rsp_ready(1'b1), .rsp_rdata(rd15), .rsp_err(err15),
    .busy(busy15)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge; returns at the negedge after the
  // accept edge with req_valid dropped.
  task automatic issue(input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    req_valid = 1'b1; req_we = we; req_size = size;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Counts cycles from the accept cycle until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err);
    int lat;
    issue(we, size, addr, wdata);
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_data"}, rsp_rdata, exp_data);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int cyc;
    int a1[$];
    int a15[$];

    // Reset state
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    #1 check("rel_req_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rel_req_ready_high", 32'(req_ready), 32'd1);

    // Word store / load, lane stores, aliasing
    issue(1'b1, 2'b10, 32'h8, 32'hDEADBEEF);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_req_ready", 32'(req_ready), 32'd0);
    wait_rsp(lat);
    check("st_word_lat", 32'(lat), 32'd2);
    check("st_word_data", rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    xact("ld_word", 1'b0, 2'b10, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("st_byte", 1'b1, 2'b00, 32'h9, 32'h000000AA, 32'hDEADAAEF, 1'b0);
    xact("st_half", 1'b1, 2'b01, 32'hE, 32'h00001234, 32'h12340000, 1'b0);
    xact("ld_alias", 1'b0, 2'b10, 32'h88, 32'h0, 32'hDEADAAEF, 1'b0);

    // Response backpressure with a competing request
    rsp_ready = 1'b0;
    issue(1'b1, 2'b10, 32'h10, 32'h11223344);
    wait_rsp(lat);
    check("bp_lat", 32'(lat), 32'd2);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_size = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'h11223344);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    check("bp_next_lat", 32'(lat), 32'd2);
    check("bp_next_data", rsp_rdata, 32'hDEADAAEF);
    @(negedge clk);

    // Reset during WAIT aborts the store and clears the array
    issue(1'b1, 2'b10, 32'h4, 32'h00000055);
    check("abort_in_wait", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", rsp_rdata, 32'h0);
    check("abort_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xact("abort_ld4", 1'b0, 2'b10, 32'h4, 32'h0, 32'h0, 1'b0);
    xact("abort_ld8", 1'b0, 2'b10, 32'h8, 32'h0, 32'h0, 1'b0);

    // Misaligned accesses
`ifdef DMEM_RSP_MISALIGN_ERR_EN
    xact("mis_word", 1'b1, 2'b10, 32'h6, 32'hCAFEF00D, 32'h0, 1'b1);
    xact("mis_word_ld", 1'b0, 2'b10, 32'h4, 32'h0, 32'h0, 1'b0);
    xact("mis_half", 1'b1, 2'b01, 32'h1, 32'h0000ABCD, 32'h0, 1'b1);
    xact("rsvd_ld", 1'b0, 2'b11, 32'h0, 32'h0, 32'h0, 1'b1);
    xact("mis_half_ld", 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, 1'b0);
`else
    xact("mis_word", 1'b1, 2'b10, 32'h6, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    xact("mis_word_ld", 1'b0, 2'b10, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0);
    xact("mis_half", 1'b1, 2'b01, 32'h1, 32'h0000ABCD, 32'h0000ABCD, 1'b0);
    xact("rsvd_st", 1'b1, 2'b11, 32'h0, 32'h01020304, 32'h01020304, 1'b0);
    xact("half_hi", 1'b1, 2'b01, 32'h3, 32'h00005566, 32'h55660304, 1'b0);
`endif

    // Back-to-back accept spacing for LATENCY=1 and LATENCY=15
    v1 = 1'b1; v15 = 1'b1;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (rdy1) a1.push_back(cyc);
      if (rdy15) a15.push_back(cyc);
    end
    v1 = 1'b0; v15 = 1'b0;
    check("l1_accepts", 32'(a1.size() >= 4), 32'd1);
    check("l15_accepts", 32'(a15.size() >= 3), 32'd1);
    for (int i = 1; i < a1.size() && i < 5; i++)
      check("l1_spacing", 32'(a1[i] - a1[i-1]), 32'd2);
    for (int i = 1; i < a15.size(); i++)
      check("l15_spacing", 32'(a15[i] - a15[i-1]), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the core's load/store request path.
- Accepts one load or store request at a time over a valid/ready handshake.
- Holds the request for a configurable latency, performs a byte-lane-masked access to an internal word array, and returns the result over a valid/ready response channel.
- Sits behind the MEM stage. It replaces the zero-latency data memory once the core gains stall support.

Parameters:
- ADDR_WIDTH, 5: word-address bits; the array holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width; fixed at 32 (4 byte lanes).
- LATENCY, 2: cycles from request accept to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  full addressed word, not extended (the core's extend logic selects and extends).
- rsp_err  out  1  misaligned or reserved access; constant 0 unless the optional feature is compiled in.
- busy  out  1  high in WAIT or RESP.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counter=0.
  - All array words cleared to 0.
  - req_ready rises on the first clk edge after rst deasserts.
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Accept on req_valid&&req_ready at edge T; latch we, size, addr, wdata.
    - If LATENCY=1: go to RESP.
    - Otherwise: go to WAIT with counter=LATENCY-2.
  - WAIT: req_ready=0. Decrement counter each cycle. At counter==0, the next edge performs the access and enters RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready. That edge returns to IDLE; req_ready=1 in the following cycle.
- Timing:
  - rsp_valid first high in the cycle starting at edge T+LATENCY.
  - Minimum spacing between accepts is LATENCY+1 cycles.
  - A request presented while req_ready=0 is ignored. The requester holds it; stability is not checked.
- Access at the commit edge:
  - Word index = addr[ADDR_WIDTH+1:2]; higher address bits are ignored (aliasing wrap-around).
  - Store lanes, with wdata replicated into the selected lanes:
    - byte: lane addr[1:0].
    - half: lanes {2*addr[1], 2*addr[1]+1}.
    - word: all four lanes.
  - Load: rsp_rdata = array word.
  - Store: rsp_rdata = post-write word value.
- rsp_ready held high in IDLE or WAIT has no effect.
- Reset asserted in WAIT aborts the transaction with no write. The commit edge is atomic.

Optional Feature:
- Macro DMEM_RSP_MISALIGN_ERR_EN.
- Defined:
  - Half with addr[0]=1, word with addr[1:0]!=0, or size 11 is an error.
  - Store suppressed (no lanes written); rsp_rdata=0, rsp_err=1.
  - Latency and handshake are unchanged.
- Undefined:
  - Half forced to addr[1] alignment and word to addr[1:0]=00.
  - size 11 treated as word.
  - rsp_err tied 0.

Decomposition:
- Package dmem_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - State encoding IDLE/WAIT/RESP.
  - Lane count constant 4.
- One sub-module, dmem_lane_ctrl (combinational).
  - Inputs: size, addr[1:0], wdata.
  - Outputs: 4-bit byte enable, lane-replicated write data, misalign flag.

Test Plan:
- Reset, release, LATENCY=2: store word 0xDEADBEEF to addr 0x8 (accept at T), rsp_ready=1 → rsp_valid at T+2, rsp_rdata=0xDEADBEEF; then load 0x8 returns 0xDEADBEEF.
- Byte store 0xAA to 0x9, then half store 0x1234 to 0xE → word 2 = 0xDEADAABF? No: 0xDEADAAEF; word 3 = 0x12340000.
- rsp_ready held 0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable throughout, req_ready=0, a second req_valid not accepted; accepted 1 cycle after rsp_ready rises.
- LATENCY=1 and LATENCY=15 builds: back-to-back loads with rsp_ready=1 → accepts spaced exactly 2 and 16 cycles.
- rst pulsed low during WAIT of a store 0x55 to 0x4 → no write, all outputs at reset values, load 0x4 returns 0.
- Misaligned word store to 0x6: with DMEM_RSP_MISALIGN_ERR_EN → rsp_err=1, memory unchanged; without → word 1 written, rsp_err=0.
